// File: rtl/fir_pkg.sv
// Shared constants for the FIR chain: default widths and the sample feeder state encoding.
package fir_pkg;

  localparam int FIR_DW = 8;
  localparam int FIR_K  = 8;

  localparam logic [1:0] FEED_IDLE  = 2'd0;
  localparam logic [1:0] FEED_ISSUE = 2'd1;
  localparam logic [1:0] FEED_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = FEED_IDLE,
    ST_ISSUE = FEED_ISSUE,
    ST_WAIT  = FEED_WAIT
  } feed_state_e;

endpackage

// File: rtl/fir_sample_fifo.sv
// Small sample FIFO in front of the FIR core; wrap-around pointers, flush empties it at the edge.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic signed [DW-1:0]      din,
  output logic signed [DW-1:0]      dout,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic signed [DW-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  // Full blocks a push even when a pop happens in the same cycle.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers source samples and issues them one at a time to the FIR core start/x_in interface.
// Optional watchdog on the core response: define FIR_FEEDER_TIMEOUT_EN.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DW      = FIR_DW,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic signed [DW-1:0]      s_data,
  output logic                      s_ready,
  input  logic                      flush,
  output logic                      fir_start,
  output logic signed [DW-1:0]      fir_x,
  input  logic                      fir_data_valid,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      timeout_err
);

  feed_state_e          state_p0;
  logic signed [DW-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop_go;
  logic                 wd_expire;

  assign s_ready = !full;
  assign push    = s_valid && s_ready;
  // A flush cycle neither pops nor starts a new issue.
  assign pop_go  = (state_p0 == ST_IDLE) && !empty && !flush;

  fir_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_go),
    .flush (flush),
    .din   (s_data),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Issue FSM: pop into fir_x, pulse start, hold until the core answers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      fir_x    <= '0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (pop_go) begin
            fir_x    <= head;
            state_p0 <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_p0 <= ST_WAIT;
        ST_WAIT: begin
          if (fir_data_valid || wd_expire) state_p0 <= ST_IDLE;
        end
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

  assign fir_start = (state_p0 == ST_ISSUE);
  assign busy      = (state_p0 == ST_ISSUE) || (state_p0 == ST_WAIT);

`ifdef FIR_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_p0;
  logic          timeout_p0;

  // A core answer in the expiry cycle wins over the watchdog.
  assign wd_expire = (state_p0 == ST_WAIT) && !fir_data_valid &&
                     (wd_cnt_p0 == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_p0  <= '0;
      timeout_p0 <= 1'b0;
    end else begin
      timeout_p0 <= wd_expire;
      if (state_p0 == ST_ISSUE)     wd_cnt_p0 <= '0;
      else if (state_p0 == ST_WAIT) wd_cnt_p0 <= wd_cnt_p0 + 1'b1;
    end
  end

  assign timeout_err = timeout_p0;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: table-driven single-sample vectors plus scoreboarded corner sequences.
module tb_fir_sample_feeder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic signed [7:0] s_data = '0;
  logic              s_ready;
  logic              flush = 1'b0;
  logic              fir_start;
  logic signed [7:0] fir_x;
  logic              fir_data_valid;
  logic              busy;
  logic [2:0]        level;
  logic              timeout_err;

  logic              core_fdv = 1'b0;
  logic              spur_fdv = 1'b0;
  int                core_lat = 0;
  int                core_cnt = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fdv = -100;
  logic fdv_armed = 1'b0;
  int last_start = -100;
  int starts = 0;
  logic signed [7:0] held_x = '0;
  logic signed [7:0] sb[$];

  always #5 clk = ~clk;

  assign fir_data_valid = core_fdv | spur_fdv;

  fir_sample_feeder #(.DW(8), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .flush          (flush),
    .fir_start      (fir_start),
    .fir_x          (fir_x),
    .fir_data_valid (fir_data_valid),
    .busy           (busy),
    .level          (level),
    .timeout_err    (timeout_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Core model: answers core_lat cycles after each start; 0 means stall.
  always @(negedge clk) begin
    core_fdv = 1'b0;
    if (rst) core_cnt = 0;
    else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) core_fdv = 1'b1;
      end
      if (fir_start && core_lat > 0) core_cnt = core_lat;
    end
  end

  always @(posedge clk) begin
    if (rst) fdv_armed = 1'b0;
    else if (fir_data_valid && busy && !fir_start) begin
      last_fdv  = cyc;
      fdv_armed = (level != 0);
    end
    cyc++;
  end

  // Output monitor: every start pops the scoreboard, fir_x held while busy.
  always @(negedge clk) begin
    if (!rst && fir_start) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got fir_x=%0d expected no start at cycle %0d", fir_x, cyc);
      end else begin
        chk("start_order", int'(fir_x), int'(sb.pop_front()));
      end
      if (fdv_armed && last_fdv > last_start) chk("start_gap", cyc - last_fdv, 2);
      last_start = cyc;
      held_x = fir_x;
      starts++;
    end else if (!rst && busy) begin
      chk("x_hold", int'(fir_x), int'(held_x));
    end
  end

  task automatic push1(input logic signed [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    if (s_ready && !flush) sb.push_back(d);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic spur_pulse();
    spur_fdv = 1'b1;
    @(negedge clk);
    spur_fdv = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((busy || level != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(n < 500), 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic signed [7:0] data;
    int                lat;
    int                exp_x;
    int                exp_busy;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int n, blen, st, max_lvl, rdy_all, s33, to_cnt, to_cyc, busy_low;
    logic signed [7:0] burst[4];

    vecs[0] = '{8'sd5,    6, 5,    7};
    vecs[1] = '{-8'sd1,   3, -1,   4};
    vecs[2] = '{8'sd127,  1, 127,  2};
    vecs[3] = '{-8'sd128, 4, -128, 5};
    burst[0] = -8'sd3;
    burst[1] = 8'sd7;
    burst[2] = 8'sd127;
    burst[3] = -8'sd128;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(fir_start), 0);
    chk("rst_x", int'(fir_x), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(s_ready), 1);

    // Single-sample vectors: start latency, value and busy duration
    for (int i = 0; i < 4; i++) begin
      core_lat = vecs[i].lat;
      push1(vecs[i].data);
      n = 1;
      while (!fir_start && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("start_delay", n, 2);
      chk("start_x", int'(fir_x), vecs[i].exp_x);
      blen = 1;
      @(negedge clk);
      while (busy && blen < 100) begin
        blen++;
        @(negedge clk);
      end
      chk("busy_len", blen, vecs[i].exp_busy);
    end

    // Burst of four with a 12-cycle core
    core_lat = 12;
    st = starts;
    max_lvl = 0;
    rdy_all = 1;
    for (int i = 0; i < 4; i++) begin
      if (!s_ready) rdy_all = 0;
      push1(burst[i]);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    chk("burst_ready", rdy_all, 1);
    chk("burst_max_level", max_lvl, 3);
    wait_drain("burst_drain");
    chk("burst_starts", starts - st, 4);

    // Fill while the core stalls
    core_lat = 0;
    push1(8'sd10);
    push1(8'sd20);
    push1(8'sd30);
    push1(8'sd40);
    push1(8'sd50);
    chk("full_level", int'(level), 4);
    chk("full_ready", int'(s_ready), 0);
    s_valid = 1'b1;
    s_data  = 8'sd60;
    @(negedge clk);
    s_data  = 8'sd61;
    @(negedge clk);
    s_valid = 1'b0;
    chk("full_reject_level", int'(level), 4);
    core_lat = 3;
    spur_pulse();
    chk("full_ready_hold", int'(s_ready), 0);
    @(negedge clk);
    chk("ready_after_pop", int'(s_ready), 1);
    chk("level_after_pop", int'(level), 3);
    wait_drain("fill_drain");

    // Flush with three buffered during WAIT, plus a push in the flush cycle
    core_lat = 0;
    push1(8'sd1);
    push1(8'sd2);
    push1(8'sd3);
    push1(8'sd4);
    repeat (2) @(negedge clk);
    chk("pre_flush_level", int'(level), 3);
    chk("pre_flush_busy", int'(busy), 1);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'sd99;
    sb.delete();
    @(negedge clk);
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("flush_level", int'(level), 0);
    chk("flush_busy_kept", int'(busy), 1);
    st = starts;
    spur_pulse();
    repeat (6) @(negedge clk);
    chk("flush_no_start", starts - st, 0);
    chk("flush_idle", int'(busy), 0);

    // Spurious fir_data_valid while idle and empty
    st = starts;
    spur_pulse();
    repeat (3) @(negedge clk);
    chk("spur_no_start", starts - st, 0);
    chk("spur_busy", int'(busy), 0);
    chk("spur_level", int'(level), 0);

    // Reset in the middle of WAIT with one sample still buffered
    push1(8'sd9);
    push1(8'sd11);
    repeat (3) @(negedge clk);
    chk("wait_busy", int'(busy), 1);
    chk("wait_x", int'(fir_x), 9);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_start", int'(fir_start), 0);
    chk("midrst_x", int'(fir_x), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_timeout", int'(timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", int'(s_ready), 1);
    st = starts;
    repeat (5) @(negedge clk);
    chk("midrst_no_start", starts - st, 0);

    // Core never answers
    core_lat = 0;
    st = starts;
    push1(8'sd33);
    push1(8'sd44);
    @(negedge clk);
    s33 = last_start;
    to_cnt = 0;
    to_cyc = -1;
    busy_low = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        to_cnt++;
        if (to_cyc < 0) to_cyc = cyc;
      end
      if (!busy) busy_low++;
    end
`ifdef FIR_FEEDER_TIMEOUT_EN
    chk("timeout_pulses", to_cnt, 1);
    chk("timeout_delay", to_cyc - s33, 17);
    chk("timeout_next_issue", starts - st, 2);
`else
    chk("timeout_pulses", to_cnt, 0);
    chk("timeout_busy_low", busy_low, 0);
    chk("timeout_level", int'(level), 1);
    chk("timeout_starts", starts - st, 1);
`endif
    do_reset();
    chk("final_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks", checks);
    $fatal(1);
  end

endmodule
